// File: rtl/dec38_pkg.sv
// Shared state encoding and seven-segment digit patterns for the decoder/display blocks.
package dec38_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  // Active-high {a,b,c,d,e,f,g,dp}; dp is never lit.
  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_lut.sv
// Combinational 3-bit digit to active-low seven-segment pattern (dp off).
// Zero latency, no flow control.
module seg7_lut
  import dec38_pkg::*;
(
  input  logic [2:0] digit_i,
  output logic [7:0] seg_n_o
);

  logic [7:0] seg_hi;

  always_comb begin
    seg_hi = SEG_0;
    case (digit_i)
      3'd0: seg_hi = SEG_0;
      3'd1: seg_hi = SEG_1;
      3'd2: seg_hi = SEG_2;
      3'd3: seg_hi = SEG_3;
      3'd4: seg_hi = SEG_4;
      3'd5: seg_hi = SEG_5;
      3'd6: seg_hi = SEG_6;
      default: seg_hi = SEG_7;
    endcase
  end

  assign seg_n_o = ~seg_hi;

endmodule

// File: rtl/dec38_scan.sv
// Registered 3-to-8 decoder with direct-load and prescaled scan modes; one-cycle
// latency from inputs to all outputs, no backpressure (free-running display driver).
module dec38_scan
  import dec38_pkg::*;
#(
  parameter int                 DIV_W   = 24,
  parameter logic [DIV_W-1:0]   DIV_MAX = DIV_W'(4_999_999)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_mode,
  input  logic [2:0] i_code,
  input  logic       i_load,
  input  logic       i_dir,
  output logic [2:0] o_code,
  output logic [7:0] o_onehot,
  output logic [7:0] o_seg,
  output logic       o_valid,
  output logic       o_wrap
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [2:0]       code_q, code_d;
  logic [7:0]       onehot_q;
  logic [7:0]       seg_q;
  logic             valid_q;
  logic             wrap_q, wrap_d;
  logic             stay_scan;
  logic             step;
  logic [7:0]       seg_d;

  seg7_lut u_seg7_lut (
    .digit_i (code_d),
    .seg_n_o (seg_d)
  );

  always_comb begin
    state_d   = ST_IDLE;
    if (i_en) state_d = i_mode ? ST_SCAN : ST_DIRECT;

    // Steps only happen while remaining in SCAN; a state change always wins.
    stay_scan = (state_q == ST_SCAN) && (state_d == ST_SCAN);
    step      = stay_scan && (presc_q == DIV_MAX);

    presc_d = '0;
    if (stay_scan && !step) presc_d = presc_q + DIV_W'(1);

    code_d = code_q;
    if (state_d == ST_DIRECT && i_load) begin
      code_d = i_code;
    end else if (step) begin
      code_d = i_dir ? (code_q - 3'd1) : (code_q + 3'd1);
    end

    wrap_d = step && (i_dir ? (code_q == 3'd0) : (code_q == 3'd7));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      code_q   <= 3'd0;
      onehot_q <= 8'h00;
      seg_q    <= SEG_BLANK;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      code_q  <= code_d;
      wrap_q  <= wrap_d;
      if (state_d == ST_IDLE) begin
        onehot_q <= 8'h00;
        seg_q    <= SEG_BLANK;
        valid_q  <= 1'b0;
      end else begin
        onehot_q <= 8'd1 << code_d;
        seg_q    <= seg_d;
        valid_q  <= 1'b1;
      end
    end
  end

  assign o_code   = code_q;
  assign o_onehot = onehot_q;
  assign o_seg    = seg_q;
  assign o_valid  = valid_q;
  assign o_wrap   = wrap_q;

endmodule

// File: tb/tb_dec38_scan.sv
// Directed bench for dec38_scan with a 4-clock scan step; expectations are hand-computed.
module tb_dec38_scan;

  logic       clk = 1'b0;
  logic       rst, en, mode, load, dir;
  logic [2:0] code;
  logic [2:0] o_code;
  logic [7:0] o_onehot, o_seg;
  logic       o_valid, o_wrap;

  int total = 0;
  int bad   = 0;

  dec38_scan #(.DIV_W(24), .DIV_MAX(24'd3)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_mode   (mode),
    .i_code   (code),
    .i_load   (load),
    .i_dir    (dir),
    .o_code   (o_code),
    .o_onehot (o_onehot),
    .o_seg    (o_seg),
    .o_valid  (o_valid),
    .o_wrap   (o_wrap)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] c, input logic [7:0] oh,
                         input logic [7:0] sg, input logic v, input logic w);
    chk({tag, ".code"},   {5'd0, o_code}, {5'd0, c});
    chk({tag, ".onehot"}, o_onehot, oh);
    chk({tag, ".seg"},    o_seg, sg);
    chk({tag, ".valid"},  {7'd0, o_valid}, {7'd0, v});
    chk({tag, ".wrap"},   {7'd0, o_wrap}, {7'd0, w});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b1; load = 1'b0; dir = 1'b0; code = 3'd0;

    // 1. reset while enabled in SCAN
    tick(2);
    chk_all("reset", 3'd0, 8'h00, 8'hFF, 1'b0, 1'b0);

    // 2. direct load
    rst = 1'b0; mode = 1'b0;
    tick(1);
    chk_all("direct_idle0", 3'd0, 8'h01, 8'h03, 1'b1, 1'b0);
    code = 3'd5; load = 1'b1;
    tick(1);
    load = 1'b0;
    chk_all("direct_load5", 3'd5, 8'h20, 8'h49, 1'b1, 1'b0);
    code = 3'd2;
    tick(1);
    chk_all("direct_noload", 3'd5, 8'h20, 8'h49, 1'b1, 1'b0);

    // 3. scan up from 6 with wrap
    code = 3'd6; load = 1'b1;
    tick(1);
    load = 1'b0; mode = 1'b1;
    tick(1);
    chk_all("up_entry6", 3'd6, 8'h40, 8'h41, 1'b1, 1'b0);
    tick(3);
    chk_all("up_hold6", 3'd6, 8'h40, 8'h41, 1'b1, 1'b0);
    tick(1);
    chk_all("up_step7", 3'd7, 8'h80, 8'h1F, 1'b1, 1'b0);
    tick(4);
    chk_all("up_wrap0", 3'd0, 8'h01, 8'h03, 1'b1, 1'b1);
    tick(1);
    chk("up_wrap_drop", {7'd0, o_wrap}, 8'h00);
    tick(3);
    chk_all("up_step1", 3'd1, 8'h02, 8'h9F, 1'b1, 1'b0);

    // 4. scan down from 1; direction changes before the next step
    dir = 1'b1;
    tick(4);
    chk_all("dn_step0", 3'd0, 8'h01, 8'h03, 1'b1, 1'b0);
    tick(4);
    chk_all("dn_wrap7", 3'd7, 8'h80, 8'h1F, 1'b1, 1'b1);
    tick(1);
    chk("dn_wrap_drop", {7'd0, o_wrap}, 8'h00);

    // 5. disable mid-scan at code 3, then resume
    mode = 1'b0; dir = 1'b0; code = 3'd3; load = 1'b1;
    tick(1);
    load = 1'b0; mode = 1'b1;
    tick(2);
    en = 1'b0;
    tick(1);
    chk_all("dis_blank", 3'd3, 8'h00, 8'hFF, 1'b0, 1'b0);
    load = 1'b1; code = 3'd6;
    tick(2);
    load = 1'b0;
    chk_all("dis_ignore_load", 3'd3, 8'h00, 8'hFF, 1'b0, 1'b0);
    en = 1'b1;
    tick(1);
    chk_all("reen_entry3", 3'd3, 8'h08, 8'h0D, 1'b1, 1'b0);
    tick(3);
    chk("reen_hold3", {5'd0, o_code}, 8'h03);
    tick(1);
    chk_all("reen_step4", 3'd4, 8'h10, 8'h99, 1'b1, 1'b0);

    // 6. load ignored in SCAN; mode switch on the terminal-count edge suppresses the step
    code = 3'd7; load = 1'b1;
    tick(1);
    load = 1'b0;
    chk("scan_ignore_load", {5'd0, o_code}, 8'h04);
    tick(2);
    mode = 1'b0;
    tick(1);
    chk_all("switch_nostep", 3'd4, 8'h10, 8'h99, 1'b1, 1'b0);
    tick(4);
    chk("direct_holds", {5'd0, o_code}, 8'h04);

    // reset mid-scan
    mode = 1'b1;
    tick(6);
    rst = 1'b1;
    tick(1);
    chk_all("reset_midscan", 3'd0, 8'h00, 8'hFF, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
